// File: rtl/pb_intc_pkg.sv
// Shared definitions for the Picoblaze interrupt controller: register offsets,
// FSM state encoding and the fixed-priority helper.
package pb_intc_pkg;

    localparam logic [7:0] PB_INTC_PENDING = 8'd0;
    localparam logic [7:0] PB_INTC_ENABLE  = 8'd1;
    localparam logic [7:0] PB_INTC_MODE    = 8'd2;
    localparam logic [7:0] PB_INTC_VECTOR  = 8'd3;
    localparam logic [7:0] PB_INTC_RAW     = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACKED  = 2'd2
    } state_e;

    // Index of the lowest set bit; lowest index has highest priority.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pb_intc_sync.sv
// Single-bit synchroniser for one interrupt source, followed by a history flop
// that turns a synchronised 0->1 transition into a one-cycle rise pulse.
module pb_intc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic irq_sync,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign irq_sync = sync_q[SYNC_STAGES-1];
    assign irq_rise = irq_sync & ~prev_q;

endmodule

// File: rtl/pb_intc.sv
// Port-mapped interrupt controller for KCPSM6: per-source edge/level pending
// latches, enable mask, fixed-priority vector and interrupt/ack handshake FSM.
module pb_intc
    import pb_intc_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         NUM_SOURCES  = 8,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             port_id,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic                   read_strobe,
    input  logic                   write_strobe,
    input  logic [NUM_SOURCES-1:0] irq_in,
    output logic                   interrupt,
    input  logic                   interrupt_ack
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);

    logic [NUM_SOURCES-1:0] raw_src, rise_src;
    logic [7:0]             raw, rise;
    logic [7:0]             offset, w1c, pending, active, vector;
    logic                   req;
    logic                   unused_read_strobe;

    logic [7:0] enable_q, enable_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] data_out_q, data_out_d;
    state_e     state_q, state_d;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_sync
        pb_intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk       (clk),
            .reset     (reset),
            .irq_async (irq_in[i]),
            .irq_sync  (raw_src[i]),
            .irq_rise  (rise_src[i])
        );
    end

    assign unused_read_strobe = read_strobe;
    assign offset             = port_id - BASE_ADDRESS;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        raw       = '0;
        rise      = '0;
        w1c       = '0;
        enable_d  = enable_q;
        mode_d    = mode_q;
        raw[NUM_SOURCES-1:0]  = raw_src;
        rise[NUM_SOURCES-1:0] = rise_src;

        if (write_strobe) begin
            case (offset)
                PB_INTC_PENDING: w1c      = data_in & SRC_MASK;
                PB_INTC_ENABLE:  enable_d = data_in & SRC_MASK;
                PB_INTC_MODE:    mode_d   = data_in & SRC_MASK;
                default: ;
            endcase
        end

        // Edge latches only live while in edge mode, so switching level->edge
        // always starts from a cleared bit; a rise beats a same-cycle W1C.
        pend_d  = mode_q & ((pend_q & ~w1c) | rise);
        pending = (pend_q & mode_q) | (raw & ~mode_q);
        active  = pending & enable_q;
        req     = |active;
        vector  = req ? {1'b1, 4'b0000, lowest_idx(active)} : 8'h00;

        case (offset)
            PB_INTC_PENDING: data_out_d = pending;
            PB_INTC_ENABLE:  data_out_d = enable_q;
            PB_INTC_MODE:    data_out_d = mode_q;
            PB_INTC_VECTOR:  data_out_d = vector;
            PB_INTC_RAW:     data_out_d = raw;
            default:         data_out_d = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = ST_ASSERT;
            ST_ASSERT: begin
                if (interrupt_ack) state_d = ST_ACKED;
                else if (!req)     state_d = ST_IDLE;
            end
            ST_ACKED:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q   <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            data_out_q <= '0;
            state_q    <= ST_IDLE;
        end else begin
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            data_out_q <= data_out_d;
            state_q    <= state_d;
        end
    end

    assign data_out  = data_out_q;
    assign interrupt = (state_q == ST_ASSERT);

endmodule

// File: tb/tb_pb_intc.sv
// Scoreboarded bench for pb_intc: directed handshake/priority/masking scenarios
// followed by randomized register traffic checked against a step-level model.
module tb_pb_intc;

    localparam logic [7:0] BASE   = 8'h00;
    localparam int         NS     = 8;
    localparam int         SS     = 2;
    localparam logic [7:0] O_PEND = 8'd0;
    localparam logic [7:0] O_EN   = 8'd1;
    localparam logic [7:0] O_MODE = 8'd2;
    localparam logic [7:0] O_VEC  = 8'd3;
    localparam logic [7:0] O_RAW  = 8'd4;

    logic          clk           = 1'b0;
    logic          reset         = 1'b0;
    logic [7:0]    port_id       = 8'h00;
    logic [7:0]    data_in       = 8'h00;
    logic [7:0]    data_out;
    logic          read_strobe   = 1'b0;
    logic          write_strobe  = 1'b0;
    logic [NS-1:0] irq_in        = '0;
    logic          interrupt;
    logic          interrupt_ack = 1'b0;

    always #5 clk = ~clk;

    pb_intc #(.BASE_ADDRESS(BASE), .NUM_SOURCES(NS), .SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .data_in       (data_in),
        .data_out      (data_out),
        .read_strobe   (read_strobe),
        .write_strobe  (write_strobe),
        .irq_in        (irq_in),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    typedef struct {
        int         cyc;
        bit         is_irq;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    // Behavioural model state for the randomized phase.
    logic [7:0] m_mode = 8'h00, m_en = 8'h00, m_pend = 8'h00, m_raw = 8'h00;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void compare(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            cur = sb.pop_front();
            compare(cur.name, cur.is_irq ? {7'b0, interrupt} : data_out, cur.exp);
        end
    end

    function automatic logic [7:0] m_pending();
        return (m_pend & m_mode) | (m_raw & ~m_mode);
    endfunction

    function automatic logic [7:0] m_vector();
        logic [7:0] a;
        a = m_pending() & m_en;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) return 8'h80 | 8'(i);
        end
        return 8'h00;
    endfunction

    task automatic step();
        @(negedge clk);
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input bit is_irq, input logic [7:0] exp, input string name);
        exp_t e;
        e.cyc    = cyc_cnt + 1;
        e.is_irq = is_irq;
        e.exp    = exp;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input bit v, input string name);
        push(1'b1, {7'b0, v}, name);
    endtask

    task automatic rd(input logic [7:0] off, input logic [7:0] exp, input string name);
        port_id     = BASE + off;
        read_strobe = 1'b1;
        push(1'b0, exp, name);
        step();
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        port_id      = BASE + off;
        data_in      = d;
        write_strobe = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] nm, ne, ni, nw;

        // Reset held with all requests high: everything reads zero.
        reset  = 1'b0;
        irq_in = '1;
        @(negedge clk);
        exp_irq(1'b0, "rst_irq"); rd(O_PEND, 8'h00, "rst_pending");
        exp_irq(1'b0, "rst_irq"); rd(O_EN,   8'h00, "rst_enable");
        exp_irq(1'b0, "rst_irq"); rd(O_MODE, 8'h00, "rst_mode");
        exp_irq(1'b0, "rst_irq"); rd(O_VEC,  8'h00, "rst_vector");
        exp_irq(1'b0, "rst_irq"); rd(O_RAW,  8'h00, "rst_raw");
        irq_in = '0;
        step();
        reset = 1'b1;
        step();
        rd(O_PEND, 8'h00, "post_rst_pending");

        // Edge path: latency, ack, W1C without re-assert.
        wr(O_MODE, 8'h01);
        wr(O_EN,   8'h01);
        irq_in[0] = 1'b1;
        step();
        irq_in[0] = 1'b0;
        for (int k = 1; k <= SS + 1; k++) begin
            exp_irq(k == SS + 1, "edge_latency");
            step();
        end
        exp_irq(1'b1, "edge_hold"); rd(O_PEND, 8'h01, "edge_pending");
        interrupt_ack = 1'b1;
        exp_irq(1'b0, "edge_ack");
        step();
        exp_irq(1'b0, "edge_w1c_irq"); wr(O_PEND, 8'h01);
        exp_irq(1'b0, "edge_w1c_irq"); rd(O_PEND, 8'h00, "edge_w1c_pending");
        exp_irq(1'b0, "edge_no_reassert"); step();
        exp_irq(1'b0, "edge_no_reassert"); step();

        // Level path: ack gap, re-assert, withdraw on drop.
        wr(O_MODE, 8'h00);
        wr(O_EN,   8'h04);
        irq_in[2] = 1'b1;
        for (int k = 0; k <= SS + 1; k++) begin
            exp_irq(k >= SS, "level_latency");
            step();
        end
        exp_irq(1'b1, "level_hold"); rd(O_PEND, 8'h04, "level_pending");
        interrupt_ack = 1'b1;
        exp_irq(1'b0, "level_ack"); step();
        exp_irq(1'b0, "level_gap"); step();
        exp_irq(1'b1, "level_reassert"); step();
        irq_in[2] = 1'b0;
        for (int k = 0; k <= SS + 1; k++) begin
            exp_irq(k < SS, "level_drop");
            step();
        end
        rd(O_PEND, 8'h00, "level_pending_clear");

        // Priority encoder.
        wr(O_MODE, 8'hFF);
        wr(O_EN,   8'hFF);
        irq_in = 8'h28;
        idle(SS + 2);
        rd(O_VEC, 8'h83, "prio_both");
        wr(O_PEND, 8'h08);
        rd(O_VEC, 8'h85, "prio_bit5");
        wr(O_PEND, 8'h20);
        rd(O_VEC, 8'h00, "prio_none");
        irq_in = '0;
        idle(SS + 2);

        // Masking and set-beats-clear collision.
        wr(O_EN, 8'h00);
        irq_in[1] = 1'b1;
        step();
        irq_in[1] = 1'b0;
        idle(SS + 2);
        exp_irq(1'b0, "mask_irq"); rd(O_PEND, 8'h02, "mask_pending");
        irq_in[1] = 1'b1;
        idle(SS);
        exp_irq(1'b0, "mask_irq"); wr(O_PEND, 8'h02);
        exp_irq(1'b0, "mask_irq"); rd(O_PEND, 8'h02, "collision_pending");
        exp_irq(1'b0, "mask_irq"); wr(O_EN, 8'h02);
        exp_irq(1'b1, "mask_release"); step();
        exp_irq(1'b1, "mask_release_hold"); step();

        // Reset while the interrupt is asserted.
        reset  = 1'b0;
        irq_in = '0;
        #1;
        compare("rst_async_irq", {7'b0, interrupt}, 8'h00);
        idle(2);
        reset = 1'b1;
        step();
        exp_irq(1'b0, "post_rst_irq"); rd(O_EN,   8'h00, "post_rst_enable");
        exp_irq(1'b0, "post_rst_irq"); rd(O_MODE, 8'h00, "post_rst_mode");
        exp_irq(1'b0, "post_rst_irq"); rd(O_PEND, 8'h00, "post_rst_pending2");

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            nm = 8'($urandom);
            ne = 8'($urandom);
            ni = 8'($urandom);
            nw = 8'($urandom);
            wr(O_MODE, nm);
            m_pend = m_pend & m_mode & nm;
            m_mode = nm;
            wr(O_EN, ne);
            m_en = ne;
            irq_in = ni;
            idle(SS + 3);
            m_pend = m_pend | (m_mode & ~m_raw & ni);
            m_raw  = ni;
            wr(O_PEND, nw);
            m_pend = m_pend & ~nw;
            rd(O_PEND, m_pending(), "rand_pending");
            rd(O_VEC,  m_vector(),  "rand_vector");
            exp_irq(|(m_pending() & m_en), "rand_irq");
            rd(O_RAW,  m_raw,  "rand_raw");
            rd(O_MODE, m_mode, "rand_mode");
            rd(O_EN,   m_en,   "rand_enable");
            rd(8'd5 + 8'($urandom_range(0, 200)), 8'h00, "rand_unmapped");
        end

        idle(3);
        compare("sb_drained", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
